// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - fetch vs load/store arbiter for the shared unified memory
module rv32i_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inst_req,
  input  logic [ADDR_WIDTH-1:0] i_inst_addr,
  output logic                  o_inst_ack,
  output logic [31:0]           o_inst_rdata,
  input  logic                  i_data_req,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic                  i_data_wr_en,
  input  logic [3:0]            i_data_wr_mask,
  input  logic [31:0]           i_data_wdata,
  output logic                  o_data_ack,
  output logic [31:0]           o_data_rdata,
  output logic                  o_mem_stb,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [3:0]            o_mem_wr_mask,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_bus_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  owner_data_q, owner_data_d;
  logic [3:0]            starve_q, starve_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  mem_stb_q, mem_stb_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [3:0]            mem_wr_mask_q, mem_wr_mask_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  inst_ack_q, inst_ack_d;
  logic [31:0]           inst_rdata_q, inst_rdata_d;
  logic                  data_ack_q, data_ack_d;
  logic [31:0]           data_rdata_q, data_rdata_d;
  logic                  bus_error_q, bus_error_d;

  // Fetch wins only when it is alone or data has used up its burst allowance.
  logic grant_fetch, grant_data, timed_out;
  assign grant_fetch = i_inst_req && (!i_data_req || (starve_q == BURST_LIMIT));
  assign grant_data  = i_data_req && !grant_fetch;
  assign timed_out   = (tmo_q == TMO_LAST);

  // State and all registered outputs; reset clears everything, including pending acks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      owner_data_q  <= 1'b0;
      starve_q      <= '0;
      tmo_q         <= '0;
      mem_stb_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_mask_q <= '0;
      mem_wdata_q   <= '0;
      inst_ack_q    <= 1'b0;
      inst_rdata_q  <= '0;
      data_ack_q    <= 1'b0;
      data_rdata_q  <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_data_q  <= owner_data_d;
      starve_q      <= starve_d;
      tmo_q         <= tmo_d;
      mem_stb_q     <= mem_stb_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_mask_q <= mem_wr_mask_d;
      mem_wdata_q   <= mem_wdata_d;
      inst_ack_q    <= inst_ack_d;
      inst_rdata_q  <= inst_rdata_d;
      data_ack_q    <= data_ack_d;
      data_rdata_q  <= data_rdata_d;
      bus_error_q   <= bus_error_d;
    end
  end

  // Next state: grant from IDLE, leave WAIT on ack or timeout, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_inst_req || i_data_req) state_d = ST_WAIT;
      ST_WAIT: if (i_mem_ack || timed_out) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture the winner, count WAIT cycles, deliver ack to the owner.
  always_comb begin
    owner_data_d  = owner_data_q;
    starve_d      = starve_q;
    tmo_d         = tmo_q;
    mem_stb_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_wr_mask_d = mem_wr_mask_q;
    mem_wdata_d   = mem_wdata_q;
    inst_ack_d    = 1'b0;
    inst_rdata_d  = inst_rdata_q;
    data_ack_d    = 1'b0;
    data_rdata_d  = data_rdata_q;
    bus_error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (grant_fetch) begin
          mem_stb_d     = 1'b1;
          mem_addr_d    = i_inst_addr;
          mem_wr_en_d   = 1'b0;
          mem_wr_mask_d = '0;
          mem_wdata_d   = '0;
          owner_data_d  = 1'b0;
          starve_d      = '0;
        end else if (grant_data) begin
          mem_stb_d     = 1'b1;
          mem_addr_d    = i_data_addr;
          mem_wr_en_d   = i_data_wr_en;
          mem_wr_mask_d = i_data_wr_mask;
          mem_wdata_d   = i_data_wdata;
          owner_data_d  = 1'b1;
          if (!i_inst_req)            starve_d = '0;
          else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (i_mem_ack) begin
          if (owner_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = i_mem_rdata;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = i_mem_rdata;
          end
        end else if (timed_out) begin
          bus_error_d = 1'b1;
          if (owner_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = '0;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_inst_ack    = inst_ack_q;
  assign o_inst_rdata  = inst_rdata_q;
  assign o_data_ack    = data_ack_q;
  assign o_data_rdata  = data_rdata_q;
  assign o_mem_stb     = mem_stb_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wr_en   = mem_wr_en_q;
  assign o_mem_wr_mask = mem_wr_mask_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_bus_error   = bus_error_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - randomized scoreboard bench for rv32i_mem_arbiter
module tb_rv32i_mem_arbiter;
  localparam int AW = 32, TMO = 16, MAXB = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic i_inst_req = 0, i_data_req = 0, i_data_wr_en = 0, i_mem_ack = 0;
  logic [AW-1:0] i_inst_addr = '0, i_data_addr = '0;
  logic [3:0] i_data_wr_mask = '0;
  logic [31:0] i_data_wdata = '0, i_mem_rdata = '0;
  logic o_inst_ack, o_data_ack, o_mem_stb, o_mem_wr_en, o_bus_error;
  logic [31:0] o_inst_rdata, o_data_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0] o_mem_wr_mask;

  rv32i_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .MAX_DATA_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .o_inst_ack(o_inst_ack), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_wr_en(i_data_wr_en),
    .i_data_wr_mask(i_data_wr_mask), .i_data_wdata(i_data_wdata), .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
    .o_mem_stb(o_mem_stb), .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_mask(o_mem_wr_mask),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_bus_error(o_bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct { bit is_data; logic [31:0] rdata; bit err; int due; } exp_t;
  exp_t sb[$];
  logic [31:0] exp_ird = '0, exp_drd = '0;

  bit busy = 0, idle_prev = 0, req_en = 0, burst_mode = 0, force_never = 0;
  int stb_cyc = 0, due_cyc = 0, last_due = 0, stray_cyc = -1, lat = 0, burst = 0, igap = 0, dgap = 0;
  bit snap_ireq = 0, snap_dreq = 0, snap_dwr = 0;
  logic [31:0] snap_iaddr = '0, snap_daddr = '0, snap_dwdata = '0, m_addr = '0, m_wdata = '0, rsp_rdata = '0;
  logic [3:0] snap_dmask = '0, m_mask = '0;
  logic m_wr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    busy = 0; burst = 0; exp_ird = '0; exp_drd = '0; stray_cyc = -1;
    idle_prev = 0; snap_ireq = 0; snap_dreq = 0; last_due = cyc; igap = 0; dgap = 0;
  endtask

  // One bench cycle: check the grant against the arbitration rules, play memory, drive requesters.
  task automatic tick();
    bit exp_stb, win_data;
    exp_t e;
    @(negedge clk);
    exp_stb = idle_prev && (snap_ireq || snap_dreq);
    if (!busy) begin
      chk("mem_stb", 64'(o_mem_stb), 64'(exp_stb));
      if (o_mem_stb && exp_stb) begin
        win_data = snap_dreq && !(burst == MAXB && snap_ireq);
        m_addr  = win_data ? snap_daddr : snap_iaddr;
        m_wr    = win_data && snap_dwr;
        m_mask  = win_data ? snap_dmask : 4'h0;
        m_wdata = snap_dwdata;
        chk("grant_ctrl", {o_mem_addr, o_mem_wr_en, o_mem_wr_mask}, {m_addr, m_wr, m_mask});
        if (win_data) chk("grant_wdata", 64'(o_mem_wdata), 64'(m_wdata));
        burst = (win_data && snap_ireq) ? ((burst < 15) ? burst + 1 : 15) : 0;
        lat = (force_never || $urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
        stb_cyc = cyc;
        due_cyc = cyc + ((lat == 0) ? TMO : lat);
        rsp_rdata = $urandom;
        e.is_data = win_data; e.rdata = (lat == 0) ? 32'h0 : rsp_rdata;
        e.err = (lat == 0); e.due = due_cyc;
        sb.push_back(e);
        busy = 1; last_due = due_cyc;
        stray_cyc = (lat == 0) ? due_cyc + 1 : (($urandom_range(0, 3) == 0) ? due_cyc : -1);
      end
    end else begin
      chk("mem_hold", {o_mem_stb, o_mem_addr, o_mem_wr_en, o_mem_wr_mask}, {1'b0, m_addr, m_wr, m_mask});
      if (cyc == due_cyc) busy = 0;
    end
    i_mem_ack = 1'b0;
    i_mem_rdata = $urandom;
    if (busy && lat != 0 && cyc == stb_cyc + lat - 1) begin
      i_mem_ack = 1'b1; i_mem_rdata = rsp_rdata;
    end else if (cyc == stray_cyc) begin
      i_mem_ack = 1'b1;
    end
    if (i_inst_req && o_inst_ack) begin
      i_inst_req = 0; igap = burst_mode ? 0 : int'($urandom_range(0, 4));
    end
    if (!i_inst_req && req_en) begin
      if (igap == 0) begin i_inst_req = 1; i_inst_addr = $urandom & 32'hFFFF_FFFC; end
      else igap--;
    end
    if (i_data_req && o_data_ack) begin
      i_data_req = 0; dgap = burst_mode ? 0 : int'($urandom_range(0, 4));
    end
    if (!i_data_req && req_en) begin
      if (dgap == 0) begin
        i_data_req = 1; i_data_addr = $urandom; i_data_wr_en = 1'($urandom_range(0, 1));
        i_data_wr_mask = 4'($urandom_range(0, 15)); i_data_wdata = $urandom;
      end else dgap--;
    end
    snap_ireq = i_inst_req; snap_iaddr = i_inst_addr;
    snap_dreq = i_data_req; snap_daddr = i_data_addr; snap_dwr = i_data_wr_en;
    snap_dmask = i_data_wr_mask; snap_dwdata = i_data_wdata;
    idle_prev = !busy && (cyc > last_due);
  endtask

  task automatic drain();
    req_en = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy && !i_inst_req && !i_data_req && sb.size() == 0) break;
      tick();
    end
    chk("drain_idle", {busy, i_inst_req, i_data_req, sb.size() != 0}, 64'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {o_inst_ack, o_data_ack, o_bus_error, o_mem_stb, o_mem_wr_en, o_mem_wr_mask}, 64'h0);
    chk({tag, "_rdata"}, {o_inst_rdata, o_data_rdata}, 64'h0);
    chk({tag, "_mem"}, {o_mem_addr, o_mem_wdata}, 64'h0);
  endtask

  // Scoreboard monitor: every requester ack/error must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_inst_ack || o_data_ack || o_bus_error) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_ack: inst=%b data=%b err=%b with nothing outstanding (cycle %0d)",
                     o_inst_ack, o_data_ack, o_bus_error, cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_flags", {o_inst_ack, o_data_ack, o_bus_error}, {!e.is_data, e.is_data, e.err});
            chk("ack_cycle", 64'(cyc), 64'(e.due));
            if (e.is_data) exp_drd = e.rdata; else exp_ird = e.rdata;
          end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_ack: none by cycle %0d, due %0d", cyc, sb[0].due);
          sb.delete(0);
        end
        chk("inst_rdata", 64'(o_inst_rdata), 64'(exp_ird));
        chk("data_rdata", 64'(o_data_rdata), 64'(exp_drd));
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    model_clear();
    rst = 1'b0;

    req_en = 1;
    repeat (1500) tick();
    burst_mode = 1;
    repeat (300) tick();
    burst_mode = 0;
    drain();

    i_data_req = 1; i_data_addr = 32'h1080; i_data_wr_en = 0; i_data_wr_mask = 4'h0;
    force_never = 1;
    for (int k = 0; k < 10 && !busy; k++) tick();
    chk("rst_test_grant", 64'(busy), 64'h1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D; i_data_req = 0; force_never = 0;
    model_clear();
    @(negedge clk);
    i_mem_ack = 1'b0;
    chk_all_zero("in_reset");
    model_clear();
    rst = 1'b0;
    repeat (8) tick();

    req_en = 1;
    repeat (400) tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
